// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: programmable raster timing generator (pixel clock domain).
// Optional macro TIMING_SYNC_POL_EN adds per-axis sync polarity inputs.
module hdmi_timing_ctrl #(
  parameter int W            = 12,
  parameter int H_ACTIVE_DEF = 640,
  parameter int H_SS_DEF     = 656,
  parameter int H_SE_DEF     = 752,
  parameter int H_TOTAL_DEF  = 800,
  parameter int V_ACTIVE_DEF = 480,
  parameter int V_SS_DEF     = 490,
  parameter int V_SE_DEF     = 492,
  parameter int V_TOTAL_DEF  = 525,
  parameter int FC_W         = 16
) (
  input  logic            pixclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [W-1:0]    cfg_h_active,
  input  logic [W-1:0]    cfg_h_ss,
  input  logic [W-1:0]    cfg_h_se,
  input  logic [W-1:0]    cfg_h_total,
  input  logic [W-1:0]    cfg_v_active,
  input  logic [W-1:0]    cfg_v_ss,
  input  logic [W-1:0]    cfg_v_se,
  input  logic [W-1:0]    cfg_v_total,
`ifdef TIMING_SYNC_POL_EN
  input  logic            cfg_hs_pol,
  input  logic            cfg_vs_pol,
`endif
  output logic            cfg_err,
  output logic [W-1:0]    counter_x,
  output logic [W-1:0]    counter_y,
  output logic            hsync,
  output logic            vsync,
  output logic            draw_area,
  output logic            frame_start,
  output logic            running,
  output logic [FC_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_e;

  typedef struct packed {
    logic [W-1:0] ha;
    logic [W-1:0] hss;
    logic [W-1:0] hse;
    logic [W-1:0] ht;
    logic [W-1:0] va;
    logic [W-1:0] vss;
    logic [W-1:0] vse;
    logic [W-1:0] vt;
    logic         hp;
    logic         vp;
  } tcfg_t;

  localparam tcfg_t CFG_DEF = '{
    ha:  W'(H_ACTIVE_DEF),
    hss: W'(H_SS_DEF),
    hse: W'(H_SE_DEF),
    ht:  W'(H_TOTAL_DEF),
    va:  W'(V_ACTIVE_DEF),
    vss: W'(V_SS_DEF),
    vse: W'(V_SE_DEF),
    vt:  W'(V_TOTAL_DEF),
    hp:  1'b1,
    vp:  1'b1
  };

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [FC_W-1:0] fc_q, fc_d;
  tcfg_t           act_q, act_d;
  tcfg_t           shd_q, shd_d;
  tcfg_t           offer;
  logic            full_q, full_d;
  logic            err_q, err_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic            run_w;
  logic            x_last;
  logic            y_last;
  logic            last_px;
  logic            xfer;
  logic            offer_ok;
  logic            h_win;
  logic            v_win;

  // Bundle the offered fields; syncs are active-high without the polarity option.
  always_comb begin
    offer     = CFG_DEF;
    offer.ha  = cfg_h_active;
    offer.hss = cfg_h_ss;
    offer.hse = cfg_h_se;
    offer.ht  = cfg_h_total;
    offer.va  = cfg_v_active;
    offer.vss = cfg_v_ss;
    offer.vse = cfg_v_se;
    offer.vt  = cfg_v_total;
`ifdef TIMING_SYNC_POL_EN
    offer.hp  = cfg_hs_pol;
    offer.vp  = cfg_vs_pol;
`else
    offer.hp  = 1'b1;
    offer.vp  = 1'b1;
`endif
  end

  // Raster position decode and offer validation.
  always_comb begin
    run_w    = (state_q != IDLE);
    x_last   = (x_q == act_q.ht - W'(1));
    y_last   = (y_q == act_q.vt - W'(1));
    last_px  = run_w && x_last && y_last;
    xfer     = cfg_valid && !full_q;
    offer_ok = (offer.ha < offer.hss) && (offer.hss < offer.hse) &&
               (offer.hse <= offer.ht) && (offer.ht >= W'(2)) &&
               (offer.va < offer.vss) && (offer.vss < offer.vse) &&
               (offer.vse <= offer.vt) && (offer.vt >= W'(2));
    h_win    = (x_q >= act_q.hss) && (x_q < act_q.hse);
    v_win    = (y_q >= act_q.vss) && (y_q < act_q.vse);
  end

  // Run/stop sequencing: stopping only ever takes effect on the last pixel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable) state_d = RUN;
      RUN:       if (!enable) state_d = last_px ? IDLE : STOP_PEND;
      STOP_PEND: begin
        if (enable) state_d = RUN;
        else if (last_px) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Pixel/line counters and completed-frame counter.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (!run_w) begin
      x_d = '0;
      y_d = '0;
    end else if (x_last) begin
      x_d = '0;
      y_d = y_last ? '0 : y_q + W'(1);
      if (y_last) fc_d = fc_q + FC_W'(1);
    end else begin
      x_d = x_q + W'(1);
    end
  end

  // Timing outputs are registered from this cycle's counters.
  always_comb begin
    de_d = run_w && (x_q < act_q.ha) && (y_q < act_q.va);
    hs_d = run_w ? (h_win == act_q.hp) : !act_q.hp;
    vs_d = run_w ? (v_win == act_q.vp) : !act_q.vp;
  end

  // Shadow capture and frame-boundary (or idle) apply of the configuration.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    full_d = full_q;
    err_d  = xfer && !offer_ok;
    if (full_q && (!run_w || last_px)) begin
      act_d  = shd_q;
      full_d = 1'b0;
    end
    if (xfer && offer_ok) begin
      shd_d  = offer;
      full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      act_q   <= CFG_DEF;
      shd_q   <= CFG_DEF;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      full_q  <= full_d;
      err_q   <= err_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
    end
  end

  assign cfg_ready   = !full_q;
  assign cfg_err     = err_q;
  assign counter_x   = x_q;
  assign counter_y   = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign draw_area   = de_q;
  assign frame_start = run_w && (x_q == '0) && (y_q == '0);
  assign running     = run_w;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// tb_hdmi_timing_ctrl: randomized bench for hdmi_timing_ctrl with a
// pixel-index reference model plus literal timing checks.
module tb_hdmi_timing_ctrl;
  localparam int W    = 12;
  localparam int FC_W = 16;

  typedef struct {
    int ha, hss, hse, ht;
    int va, vss, vse, vt;
    bit hp, vp;
  } cfg_t;

  logic pixclk    = 1'b0;
  logic rst_n     = 1'b1;
  logic enable    = 1'b0;
  logic cfg_valid = 1'b0;
  logic [W-1:0] c_ha = '0, c_hss = '0, c_hse = '0, c_ht = '0;
  logic [W-1:0] c_va = '0, c_vss = '0, c_vse = '0, c_vt = '0;
`ifdef TIMING_SYNC_POL_EN
  logic c_hp = 1'b1, c_vp = 1'b1;
`endif
  logic cfg_ready, cfg_err;
  logic [W-1:0] counter_x, counter_y;
  logic hsync, vsync, draw_area, frame_start, running;
  logic [FC_W-1:0] frame_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  cfg_t m_act, m_shd;
  bit   m_run, m_full, m_err, m_hs, m_vs, m_de;
  int   m_p, m_fc;

  always #5 pixclk = ~pixclk;

  hdmi_timing_ctrl dut (
    .pixclk(pixclk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(c_ha), .cfg_h_ss(c_hss),
    .cfg_h_se(c_hse), .cfg_h_total(c_ht),
    .cfg_v_active(c_va), .cfg_v_ss(c_vss),
    .cfg_v_se(c_vse), .cfg_v_total(c_vt),
`ifdef TIMING_SYNC_POL_EN
    .cfg_hs_pol(c_hp), .cfg_vs_pol(c_vp),
`endif
    .cfg_err(cfg_err),
    .counter_x(counter_x), .counter_y(counter_y),
    .hsync(hsync), .vsync(vsync), .draw_area(draw_area),
    .frame_start(frame_start), .running(running),
    .frame_count(frame_count)
  );

  function automatic cfg_t mk(int ha, int hss, int hse, int ht,
                              int va, int vss, int vse, int vt);
    cfg_t c;
    c.ha = ha; c.hss = hss; c.hse = hse; c.ht = ht;
    c.va = va; c.vss = vss; c.vse = vse; c.vt = vt;
    c.hp = 1'b1; c.vp = 1'b1;
    return c;
  endfunction

  function automatic bit cfg_ok(cfg_t c);
    return c.ha < c.hss && c.hss < c.hse && c.hse <= c.ht && c.ht >= 2 &&
           c.va < c.vss && c.vss < c.vse && c.vse <= c.vt && c.vt >= 2;
  endfunction

  function automatic cfg_t offer();
    cfg_t c;
    c = mk(int'(c_ha), int'(c_hss), int'(c_hse), int'(c_ht),
           int'(c_va), int'(c_vss), int'(c_vse), int'(c_vt));
`ifdef TIMING_SYNC_POL_EN
    c.hp = c_hp;
    c.vp = c_vp;
`endif
    return c;
  endfunction

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.ha  = int'($urandom_range(0, 5));
    c.hss = c.ha + int'($urandom_range(0, 2));
    c.hse = c.hss + int'($urandom_range(1, 3));
    c.ht  = c.hse + int'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) c.ht = c.ht - 1;
    c.va  = int'($urandom_range(0, 4));
    c.vss = c.va + int'($urandom_range(0, 2));
    c.vse = c.vss + int'($urandom_range(1, 3));
    c.vt  = c.vse + int'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) c.vt = c.vt - 1;
    c.hp = 1'b1;
    c.vp = 1'b1;
`ifdef TIMING_SYNC_POL_EN
    c.hp = 1'($urandom_range(0, 1));
    c.vp = 1'($urandom_range(0, 1));
`endif
    return c;
  endfunction

  task automatic set_cfg(input cfg_t c);
    c_ha = W'(c.ha); c_hss = W'(c.hss); c_hse = W'(c.hse); c_ht = W'(c.ht);
    c_va = W'(c.va); c_vss = W'(c.vss); c_vse = W'(c.vse); c_vt = W'(c.vt);
`ifdef TIMING_SYNC_POL_EN
    c_hp = c.hp;
    c_vp = c.vp;
`endif
  endtask

  task automatic m_reset();
    m_act  = mk(640, 656, 752, 800, 480, 490, 492, 525);
    m_shd  = m_act;
    m_run  = 0; m_full = 0; m_err = 0;
    m_hs   = 0; m_vs = 0; m_de = 0;
    m_p    = 0; m_fc = 0;
  endtask

  // Frame as a linear pixel index; stopping is decided only at the last pixel.
  task automatic m_step();
    int x, y;
    bit last, xfer;
    cfg_t o;
    x    = m_p % m_act.ht;
    y    = m_p / m_act.ht;
    last = m_run && (m_p == m_act.ht * m_act.vt - 1);
    if (m_run) begin
      m_de = (x < m_act.ha) && (y < m_act.va);
      m_hs = ((x >= m_act.hss) && (x < m_act.hse)) == m_act.hp;
      m_vs = ((y >= m_act.vss) && (y < m_act.vse)) == m_act.vp;
    end else begin
      m_de = 0;
      m_hs = !m_act.hp;
      m_vs = !m_act.vp;
    end
    o     = offer();
    xfer  = cfg_valid && !m_full;
    m_err = xfer && !cfg_ok(o);
    if (m_full && (!m_run || last)) begin
      m_act  = m_shd;
      m_full = 0;
    end
    if (xfer && cfg_ok(o)) begin
      m_shd  = o;
      m_full = 1;
    end
    if (!m_run) begin
      m_p   = 0;
      m_run = enable;
    end else if (last) begin
      m_p   = 0;
      m_fc  = (m_fc + 1) % (1 << FC_W);
      m_run = enable;
    end else begin
      m_p++;
    end
  endtask

  task automatic chkn(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chkn(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic compare();
    chk1("cfg_ready", cfg_ready, !m_full);
    chk1("cfg_err", cfg_err, m_err);
    chkn("counter_x", {20'd0, counter_x}, m_p % m_act.ht);
    chkn("counter_y", {20'd0, counter_y}, m_p / m_act.ht);
    chk1("hsync", hsync, m_hs);
    chk1("vsync", vsync, m_vs);
    chk1("draw_area", draw_area, m_de);
    chk1("frame_start", frame_start, m_run && m_p == 0);
    chk1("running", running, m_run);
    chkn("frame_count", {16'd0, frame_count}, m_fc);
  endtask

  task automatic cycle();
    @(posedge pixclk);
    if (rst_n) m_step();
    @(negedge pixclk);
    if (chk_on) compare();
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!frame_start && n < 5000);
    chk1("wait_frame_start", frame_start, 1'b1);
  endtask

  task automatic wait_xy(input int x, input int y, input int lim);
    int n;
    n = 0;
    while (!(int'(counter_x) == x && int'(counter_y) == y) && n < lim) begin
      cycle();
      n++;
    end
    chk1("wait_xy", int'(counter_x) == x && int'(counter_y) == y, 1'b1);
  endtask

  initial begin
    cfg_t a, b, r;
    int n, n1, n2, cnt, first_x, fc0;
    a = mk(6, 7, 9, 10, 5, 6, 7, 8);
    b = mk(4, 5, 6, 8, 3, 4, 5, 6);
    #1 rst_n = 0;
    m_reset();
    chk_on = 1;
    repeat (3) cycle();
    chk1("rst_ready", cfg_ready, 1'b1);
    chkn("rst_x", {20'd0, counter_x}, 0);
    chk1("rst_running", running, 1'b0);
    rst_n = 1;
    cycle();

    enable = 1;
    cycle();
    chk1("first_fs", frame_start, 1'b1);
    chkn("first_x", {20'd0, counter_x}, 0);
    cnt = 0; n = 0; first_x = -1;
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (hsync) begin
        cnt++;
        if (first_x < 0) first_x = int'(counter_x);
      end
      if (draw_area) n++;
    end
    chkn("hs_len", cnt, 96);
    chkn("hs_first_x", first_x, 657);
    chkn("de_len", n, 640);
    chkn("line_wrap_y", {20'd0, counter_y}, 1);

    r = mk(640, 640, 752, 800, 480, 490, 492, 525);
    set_cfg(r);
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    chk1("bad_err", cfg_err, 1'b1);
    chk1("bad_ready", cfg_ready, 1'b1);
    cycle();
    chk1("bad_err_pulse", cfg_err, 1'b0);

    set_cfg(a);
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    chk1("shadow_full", cfg_ready, 1'b0);
    wait_xy(300, 2, 3000);
    #2 rst_n = 0;
    m_reset();
    #1;
    chkn("arst_x", {20'd0, counter_x}, 0);
    chkn("arst_y", {20'd0, counter_y}, 0);
    chk1("arst_running", running, 1'b0);
    chk1("arst_hsync", hsync, 1'b0);
    chk1("arst_de", draw_area, 1'b0);
    chk1("arst_ready", cfg_ready, 1'b1);
    cycle();
    rst_n = 1;
    cycle();
    chk1("resume_fs", frame_start, 1'b1);
    repeat (800) cycle();
    chkn("resume_y", {20'd0, counter_y}, 1);
    chkn("resume_x", {20'd0, counter_x}, 0);

    enable = 0;
    rst_n = 0;
    m_reset();
    cycle();
    rst_n = 1;
    cycle();
    set_cfg(a);
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    chk1("idle_ready_lo", cfg_ready, 1'b0);
    cycle();
    chk1("idle_ready_hi", cfg_ready, 1'b1);
    enable = 1;
    wait_fs(n);
    repeat (30) cycle();
    set_cfg(b);
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    chk1("mid_ready_lo", cfg_ready, 1'b0);
    wait_fs(n1);
    chkn("period_old", 31 + n1, 80);
    chk1("ready_after_bnd", cfg_ready, 1'b1);
    wait_fs(n2);
    chkn("period_new", n2, 48);

    wait_xy(3, 2, 200);
    fc0 = int'(frame_count);
    enable = 0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (running && n < 200);
    chkn("stop_cycles", n, 29);
    chkn("stop_x", {20'd0, counter_x}, 0);
    chkn("stop_y", {20'd0, counter_y}, 0);
    chkn("stop_fc", {16'd0, frame_count}, (fc0 + 1) % 65536);

    enable = 1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = !enable;
      cfg_valid = ($urandom_range(0, 19) == 0);
      set_cfg(rnd_cfg());
      cycle();
    end
    cfg_valid = 0;

`ifdef TIMING_SYNC_POL_EN
    enable = 0;
    rst_n = 0;
    m_reset();
    cycle();
    rst_n = 1;
    cycle();
    a.hp = 0;
    set_cfg(a);
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    repeat (3) cycle();
    chk1("idle_hs_inv", hsync, 1'b1);
    enable = 1;
    repeat (25) cycle();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!hsync) cnt++;
    end
    chkn("hs_low_len", cnt, 2);
`endif

    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
